// File: rtl/m_cnt_down_min.sv
// BCD MM:SS countdown timer with borrow chain, pause/resume and a one-cycle done pulse.
// Optional `AUTO_RELOAD_EN: on expiry, reload the last loaded preset and keep running.
module m_cnt_down_min #(
    parameter logic [3:0] SEC_HIGH_MAX = 4'd5,
    parameter logic [3:0] MIN_HIGH_MAX = 4'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_min_h,
    input  logic [3:0] ld_min_l,
    input  logic [3:0] ld_sec_h,
    input  logic [3:0] ld_sec_l,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_high,
    output logic [3:0] min_low,
    output logic [3:0] sec_high,
    output logic [3:0] sec_low,
    output logic       running,
    output logic       borrow_min,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] mh_nxt, ml_nxt, sh_nxt, sl_nxt;
    logic [3:0] c_mh, c_ml, c_sh, c_sl;
    logic       borrow_nxt, done_nxt;
    logic       is_zero, is_one;

`ifdef AUTO_RELOAD_EN
    logic [15:0] shadow, shadow_nxt;
`endif

    always_comb begin
        c_mh = (ld_min_h > MIN_HIGH_MAX) ? MIN_HIGH_MAX : ld_min_h;
        c_ml = (ld_min_l > 4'd9)         ? 4'd9         : ld_min_l;
        c_sh = (ld_sec_h > SEC_HIGH_MAX) ? SEC_HIGH_MAX : ld_sec_h;
        c_sl = (ld_sec_l > 4'd9)         ? 4'd9         : ld_sec_l;
    end

    assign is_zero = ({min_high, min_low, sec_high, sec_low} == 16'h0000);
    assign is_one  = ({min_high, min_low, sec_high, sec_low} == 16'h0001);

    always_comb begin
        state_nxt  = state;
        mh_nxt     = min_high;
        ml_nxt     = min_low;
        sh_nxt     = sec_high;
        sl_nxt     = sec_low;
        borrow_nxt = 1'b0;
        done_nxt   = 1'b0;
`ifdef AUTO_RELOAD_EN
        shadow_nxt = shadow;
`endif
        if (load) begin
            {mh_nxt, ml_nxt, sh_nxt, sl_nxt} = {c_mh, c_ml, c_sh, c_sl};
            state_nxt = IDLE;
`ifdef AUTO_RELOAD_EN
            shadow_nxt = {c_mh, c_ml, c_sh, c_sl};
`endif
        end else if (pause) begin
            if (state == RUN)
                state_nxt = PAUSE;
        end else if (start) begin
            // Starting from 00:00 is refused so done can never fire without a real countdown
            if ((state == IDLE || state == PAUSE) && !is_zero)
                state_nxt = RUN;
        end else if (tick && state == RUN) begin
            if (is_one) begin
                done_nxt = 1'b1;
                {mh_nxt, ml_nxt, sh_nxt, sl_nxt} = 16'h0000;
                state_nxt = DONE;
`ifdef AUTO_RELOAD_EN
                if (shadow != 16'h0000) begin
                    {mh_nxt, ml_nxt, sh_nxt, sl_nxt} = shadow;
                    state_nxt = RUN;
                end
`endif
            end else if (sec_low != 4'd0) begin
                sl_nxt = sec_low - 4'd1;
            end else begin
                sl_nxt = 4'd9;
                if (sec_high != 4'd0) begin
                    sh_nxt = sec_high - 4'd1;
                end else begin
                    // Seconds wrap 00 -> SEC_HIGH_MAX:9; borrow from the minutes
                    sh_nxt     = SEC_HIGH_MAX;
                    borrow_nxt = 1'b1;
                    if (min_low != 4'd0) begin
                        ml_nxt = min_low - 4'd1;
                    end else begin
                        ml_nxt = 4'd9;
                        mh_nxt = min_high - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            min_high   <= 4'd0;
            min_low    <= 4'd0;
            sec_high   <= 4'd0;
            sec_low    <= 4'd0;
            running    <= 1'b0;
            borrow_min <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            min_high   <= mh_nxt;
            min_low    <= ml_nxt;
            sec_high   <= sh_nxt;
            sec_low    <= sl_nxt;
            running    <= (state_nxt == RUN);
            borrow_min <= borrow_nxt;
            done       <= done_nxt;
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow <= 16'h0000;
        else     shadow <= shadow_nxt;
    end
`endif

endmodule

// File: tb/tb_m_cnt_down_min.sv
// Bench for m_cnt_down_min: directed scenarios plus random traffic against a
// remaining-seconds reference model.
module tb_m_cnt_down_min;

    localparam int SHM = 5;
    localparam int MHM = 5;
    localparam int SPM = (SHM + 1) * 10;
`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst, tick, load, start, pause;
    logic [3:0] ld_min_h, ld_min_l, ld_sec_h, ld_sec_l;
    logic [3:0] min_high, min_low, sec_high, sec_low;
    logic       running, borrow_min, done;
    logic [18:0] obs;
    logic [15:0] digits;

    int compared = 0, mismatched = 0;
    int m_secs, m_mode, m_shadow;
    bit m_done, m_borrow;

    m_cnt_down_min dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .ld_min_h(ld_min_h), .ld_min_l(ld_min_l), .ld_sec_h(ld_sec_h), .ld_sec_l(ld_sec_l),
        .start(start), .pause(pause),
        .min_high(min_high), .min_low(min_low), .sec_high(sec_high), .sec_low(sec_low),
        .running(running), .borrow_min(borrow_min), .done(done)
    );

    always #5 clk = ~clk;
    assign digits = {min_high, min_low, sec_high, sec_low};
    assign obs    = {digits, running, borrow_min, done};

    function automatic int clampd(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [18:0] expv();
        int mins, s;
        mins = m_secs / SPM;
        s    = m_secs % SPM;
        return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10),
                m_mode == M_RUN, m_borrow, m_done};
    endfunction

    task automatic model_reset();
        m_secs = 0; m_mode = M_IDLE; m_shadow = 0; m_done = 0; m_borrow = 0;
    endtask

    // Time is tracked as a plain count of remaining seconds.
    task automatic model_step();
        m_done = 0; m_borrow = 0;
        if (load) begin
            m_secs = (clampd(int'(ld_min_h), MHM) * 10 + clampd(int'(ld_min_l), 9)) * SPM
                   + clampd(int'(ld_sec_h), SHM) * 10 + clampd(int'(ld_sec_l), 9);
            m_shadow = m_secs;
            m_mode   = M_IDLE;
        end else if (pause) begin
            if (m_mode == M_RUN) m_mode = M_PAUSE;
        end else if (start) begin
            if ((m_mode == M_IDLE || m_mode == M_PAUSE) && m_secs != 0) m_mode = M_RUN;
        end else if (tick && m_mode == M_RUN) begin
            if (m_secs % SPM == 0) m_borrow = 1;
            m_secs--;
            if (m_secs == 0) begin
                m_done = 1;
                if (AUTO && m_shadow != 0) m_secs = m_shadow;
                else m_mode = M_DONE;
            end
        end
    endtask

    task automatic set_preset(input int mh, input int ml, input int sh, input int sl);
        ld_min_h = 4'(mh); ld_min_l = 4'(ml); ld_sec_h = 4'(sh); ld_sec_l = 4'(sl);
    endtask

    // Drive strobes for one edge, then update the model; returns at posedge+1.
    task automatic cyc(input bit ld, input bit st, input bit ps, input bit tk);
        load = ld; start = st; pause = ps; tick = tk;
        @(posedge clk); #1;
        model_step();
        load = 0; start = 0; pause = 0; tick = 0;
    endtask

    task automatic test_reset();
        rst = 1; load = 0; start = 0; pause = 0; tick = 0;
        set_preset(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (obs !== 19'd0) begin
            mismatched++; $display("FAIL reset: got %h want %h", obs, 19'd0);
        end
        rst = 0;
        cyc(0, 0, 0, 1);
        compared++;
        if (obs !== expv()) begin
            mismatched++; $display("FAIL reset_idle_tick: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_expiry();
        int dones = 0;
        set_preset(0, 0, 0, 3);
        cyc(1, 0, 0, 0);
        compared++;
        if (digits !== 16'h0003) begin
            mismatched++; $display("FAIL t1_load: got %h want 0003", digits);
        end
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1);
            dones += int'(done);
            compared++;
            if (obs !== expv()) begin
                mismatched++; $display("FAIL t1_tick%0d: got %h want %h", i, obs, expv());
            end
        end
        compared++;
        if (done !== 1'b1) begin
            mismatched++; $display("FAIL t1_done_on_third: got %b want 1", done);
        end
        cyc(0, 0, 0, 0);
        dones += int'(done);
        compared++;
        if (dones != 1) begin
            mismatched++; $display("FAIL t1_done_count: got %0d want 1", dones);
        end
        cyc(0, 0, 0, 1);
        compared++;
        if (obs !== expv()) begin
            mismatched++; $display("FAIL t1_fourth_tick: got %h want %h", obs, expv());
        end
`ifndef AUTO_RELOAD_EN
        compared++;
        if ({digits, running} !== 17'h0) begin
            mismatched++; $display("FAIL t1_hold_zero: got %h want 0", {digits, running});
        end
`endif
    endtask

    task automatic test_borrow();
        set_preset(0, 1, 0, 0);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
        compared++;
        if ({digits, borrow_min} !== {16'h0059, 1'b1}) begin
            mismatched++; $display("FAIL t2_borrow: got %h want %h", {digits, borrow_min}, {16'h0059, 1'b1});
        end
        cyc(0, 0, 0, 0);
        compared++;
        if (borrow_min !== 1'b0) begin
            mismatched++; $display("FAIL t2_borrow_pulse: got %b want 0", borrow_min);
        end
        set_preset(1, 0, 0, 0);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
        compared++;
        if (digits !== 16'h0959 || obs !== expv()) begin
            mismatched++; $display("FAIL t2_min_borrow: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_pause();
        set_preset(0, 0, 1, 0);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        repeat (5) cyc(0, 0, 0, 1);
        compared++;
        if ({digits, running} !== {16'h0008, 1'b0}) begin
            mismatched++; $display("FAIL t3_frozen: got %h want %h", {digits, running}, {16'h0008, 1'b0});
        end
        cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
        compared++;
        if (digits !== 16'h0007 || obs !== expv()) begin
            mismatched++; $display("FAIL t3_resume: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_clamp();
        int dones = 0;
        set_preset(0, 12, 7, 0);
        cyc(1, 0, 0, 0);
        compared++;
        if (digits !== 16'h0950) begin
            mismatched++; $display("FAIL t4_clamp: got %h want 0950", digits);
        end
        set_preset(9, 15, 9, 15);
        cyc(1, 0, 0, 0);
        compared++;
        if (digits !== 16'h5959) begin
            mismatched++; $display("FAIL t4_clamp_max: got %h want 5959", digits);
        end
        set_preset(0, 0, 0, 0);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1);
            dones += int'(done) + int'(running);
        end
        compared++;
        if (dones != 0 || obs !== 19'd0) begin
            mismatched++; $display("FAIL t4_zero_start: got %h/%0d want 0/0", obs, dones);
        end
    endtask

    task automatic test_async_reset();
        set_preset(0, 0, 4, 5);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 1);
        compared++;
        if (digits !== 16'h0042) begin
            mismatched++; $display("FAIL t5_pre_reset: got %h want 0042", digits);
        end
        #3 rst = 1;
        #1;
        compared++;
        if (obs !== 19'd0) begin
            mismatched++; $display("FAIL t5_async_clear: got %h want 0", obs);
        end
        model_reset();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        set_preset(0, 0, 3, 0);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1);
        cyc(0, 1, 1, 0);
        compared++;
        if (running !== 1'b0 || obs !== expv()) begin
            mismatched++; $display("FAIL t5_pause_wins: got %h want %h", obs, expv());
        end
        cyc(0, 0, 0, 1);
        compared++;
        if (digits !== 16'h0029) begin
            mismatched++; $display("FAIL t5_paused_hold: got %h want 0029", digits);
        end
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [15:0] want_d [4] = '{16'h0001, 16'h0002, 16'h0001, 16'h0002};
        logic        want_p [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        set_preset(0, 0, 0, 2);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1);
            compared++;
            if ({digits, running, done} !== {want_d[i], 1'b1, want_p[i]}) begin
                mismatched++;
                $display("FAIL t6_reload%0d: got %h want %h", i, {digits, running, done}, {want_d[i], 1'b1, want_p[i]});
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 1) == 0)
                set_preset(0, 0, $urandom_range(0, 1), $urandom_range(0, 15));
            else
                set_preset($urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 15));
            cyc($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 60);
            compared++;
            if (obs !== expv()) begin
                mismatched++; $display("FAIL random%0d: got %h want %h", n, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_expiry();
        test_borrow();
        test_pause();
        test_clamp();
        test_async_reset();
`ifdef AUTO_RELOAD_EN
        test_auto_reload();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
